detector_jogada: RTL and testbench
==================================

# detector_jogada

Input-conditioning stage directly upstream of the memory-game circuit (`circuito_exp6`). Filters the raw `botoes` inputs and makes them safe to use:
- debounces press and release;
- accepts exactly one event per physical press;
- registers the one-hot move code for the game datapath;
- raises a single-cycle `tem_jogada` pulse, or a `jogada_invalida` pulse when more than one button is held.

The game FSM consumes `jogada`/`tem_jogada` instead of sampling `botoes` directly.

## Interface
Parameters:
- `DEBOUNCE_CICLOS`, default 4: consecutive stable cycles required to accept a press or a release. Legal range 2..255.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `limpa` in 1: synchronous clear of the `jogada` register only.
- `botoes` in 4: raw button levels, asynchronous to nothing (already synchronized upstream), 1 = pressed.
- `jogada` out 4: last accepted one-hot move, held until the next accept or `limpa`.
- `tem_jogada` out 1: one-cycle pulse, valid move accepted.
- `jogada_invalida` out 1: one-cycle pulse, multi-button press accepted (`jogada` unchanged).
- `ocupado` out 1: high in any state other than OCIOSO.
- `db_estado` out 3: current state code, for debug display.

## Operation
State machine (codes for `db_estado`):
- OCIOSO 0: if `botoes`==0, stay. If nonzero, load `amostra`<=`botoes`, `cnt`<=0, go to FILTRA_PRESS.
- FILTRA_PRESS 1:
  - `botoes`==0: go to OCIOSO.
  - `botoes`!=`amostra` and nonzero: reload `amostra`, `cnt`<=0, stay.
  - Match and `cnt`==`DEBOUNCE_CICLOS`-2: go to ACEITA.
  - Match otherwise: `cnt`++.
  - If `amostra` is one-hot, `jogada`<=`amostra` on the edge entering ACEITA.
- ACEITA 2, one cycle:
  - `tem_jogada`=1 if `amostra` is one-hot, else `jogada_invalida`=1.
  - Next state ESPERA_SOLTAR, unconditionally.
- ESPERA_SOLTAR 3: if `botoes`==0, `cnt`<=0 and go to FILTRA_SOLTA; otherwise stay. Any change in `botoes` is ignored.
- FILTRA_SOLTA 4:
  - `botoes`!=0: go to ESPERA_SOLTAR.
  - `cnt`==`DEBOUNCE_CICLOS`-2: go to OCIOSO.
  - Otherwise `cnt`++.
- One-hot test: exactly one bit of `amostra` set. The value 0 cannot reach ACEITA.
- `limpa`: `jogada`<=0 on the next edge. FSM, counter and pulses are unaffected. If `limpa` coincides with the edge entering ACEITA on a valid move, the new capture wins.
- Pulses and `ocupado` are Moore outputs decoded from state plus the registered one-hot flag.

## Timing
- Reset value of every output is 0 (`jogada`=0, pulses 0, `ocupado`=0, `db_estado`=0). Internal state after reset: OCIOSO, `cnt`=0, `amostra`=0.
- Let E0 be the first edge at which `botoes` is nonzero in OCIOSO. If `botoes` stays stable, ACEITA is entered at edge E0+`DEBOUNCE_CICLOS`-1.
- Consequence: `tem_jogada` is high for exactly the one cycle after that edge, and `jogada` is valid in that same cycle.
- A press must be stable for at least `DEBOUNCE_CICLOS` sampled cycles to be accepted. With the default of 4, the 10-cycle presses used by the game bench are accepted.
- Release needs `DEBOUNCE_CICLOS` consecutive zero samples (counting the ESPERA_SOLTAR exit edge) before a new press can start.
- Minimum spacing between two accepts: 2×`DEBOUNCE_CICLOS`+1 cycles.
- Reset asserted mid-filter or mid-ACEITA: outputs drop to 0 immediately, with no pulse.
- `cnt` width is `$clog2(DEBOUNCE_CICLOS)`, minimum 1. It never wraps, because the compare terminates counting.

## Structure
- Shared package `jogo_pkg`:
  - state code constants (OCIOSO..FILTRA_SOLTA, 3 bits);
  - `LARGURA_BOTOES`=4;
  - default debounce constant.
- One sub-module, `contador_debounce`: counter with synchronous clear, enable, and a `fim` output when the count equals `DEBOUNCE_CICLOS`-2; asynchronous reset. The FSM and the `amostra`/`jogada` registers live in `detector_jogada`.

## Test plan
- Reset, then `botoes`=0001 for 10 cycles -> exactly one `tem_jogada` pulse 3 cycles after the first sampled edge. `jogada`=0001 in the pulse cycle and is held after release.
- Bounce: 0100 for 2 cycles, 0000 for 1 cycle, 0100 for 10 cycles -> one pulse only, timed from the restart. `jogada`=0100.
- `botoes`=0011 for 10 cycles -> one `jogada_invalida` pulse, no `tem_jogada`, `jogada` keeps its previous value.
- Hold 1000 for 50 cycles, glitch to 0 for 2 cycles, back to 1000 -> no second pulse. After a clean release of ≥4 cycles, the next 0010 press is accepted.
- `limpa` pulse while idle -> `jogada`=0 next cycle. `limpa` on the accept edge of 0001 -> `jogada`=0001.
- `reset` asserted in FILTRA_PRESS cycle 2 -> all outputs 0 immediately. After release, no pulse until a fresh full-length press.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared constants for the memory-game input path: state codes, button width,
// default debounce length and the one-hot test used on captured samples.
package jogo_pkg;

   localparam int LARGURA_BOTOES  = 4;
   localparam int DEBOUNCE_PADRAO = 4;

   localparam logic [2:0] OCIOSO        = 3'd0;
   localparam logic [2:0] FILTRA_PRESS  = 3'd1;
   localparam logic [2:0] ACEITA        = 3'd2;
   localparam logic [2:0] ESPERA_SOLTAR = 3'd3;
   localparam logic [2:0] FILTRA_SOLTA  = 3'd4;

   function automatic logic eh_one_hot(input logic [LARGURA_BOTOES-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/contador_debounce.sv
// Stability counter for the debouncer: clears synchronously, counts on enable,
// and flags fim once the count reaches DEBOUNCE_CICLOS-2.
module contador_debounce #(
   parameter int DEBOUNCE_CICLOS = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   localparam int LARGURA = ($clog2(DEBOUNCE_CICLOS) < 1) ? 1 : $clog2(DEBOUNCE_CICLOS);
   localparam logic [LARGURA-1:0] ALVO = LARGURA'(DEBOUNCE_CICLOS - 2);

   logic [LARGURA-1:0] cnt_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (zera) begin
         cnt_reg <= '0;
      end else if (conta) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // The FSM stops enabling once fim is seen, so the count never wraps.
   assign fim = (cnt_reg == ALVO);

endmodule

// File: rtl/detector_jogada.sv
// Debounces the game buttons and turns each physical press into one accepted
// move (tem_jogada) or one multi-button rejection (jogada_invalida).
module detector_jogada
   import jogo_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      limpa,
   input  logic [LARGURA_BOTOES-1:0] botoes,
   output logic [LARGURA_BOTOES-1:0] jogada,
   output logic                      tem_jogada,
   output logic                      jogada_invalida,
   output logic                      ocupado,
   output logic [2:0]                db_estado
);

   logic [2:0]                estado_reg, estado_next;
   logic [LARGURA_BOTOES-1:0] amostra_reg;
   logic [LARGURA_BOTOES-1:0] jogada_reg;
   logic                      um_quente_reg;
   logic                      carrega_amostra;
   logic                      zera_cnt;
   logic                      conta_cnt;
   logic                      captura;
   logic                      fim_cnt;

   contador_debounce #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
   ) u_contador (
      .clock(clock),
      .reset(reset),
      .zera (zera_cnt),
      .conta(conta_cnt),
      .fim  (fim_cnt)
   );

   always_comb begin
      estado_next     = estado_reg;
      carrega_amostra = 1'b0;
      zera_cnt        = 1'b0;
      conta_cnt       = 1'b0;
      captura         = 1'b0;
      case (estado_reg)
         OCIOSO: begin
            if (botoes != '0) begin
               carrega_amostra = 1'b1;
               zera_cnt        = 1'b1;
               estado_next     = FILTRA_PRESS;
            end
         end
         FILTRA_PRESS: begin
            if (botoes == '0) begin
               estado_next = OCIOSO;
            end else if (botoes != amostra_reg) begin
               carrega_amostra = 1'b1;
               zera_cnt        = 1'b1;
            end else if (fim_cnt) begin
               estado_next = ACEITA;
               captura     = um_quente_reg;
            end else begin
               conta_cnt = 1'b1;
            end
         end
         ACEITA: begin
            estado_next = ESPERA_SOLTAR;
         end
         ESPERA_SOLTAR: begin
            if (botoes == '0) begin
               zera_cnt    = 1'b1;
               estado_next = FILTRA_SOLTA;
            end
         end
         FILTRA_SOLTA: begin
            if (botoes != '0) begin
               estado_next = ESPERA_SOLTAR;
            end else if (fim_cnt) begin
               estado_next = OCIOSO;
            end else begin
               conta_cnt = 1'b1;
            end
         end
         default: estado_next = OCIOSO;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_reg    <= OCIOSO;
         amostra_reg   <= '0;
         um_quente_reg <= 1'b0;
      end else begin
         estado_reg <= estado_next;
         if (carrega_amostra) begin
            amostra_reg   <= botoes;
            um_quente_reg <= eh_one_hot(botoes);
         end
      end
   end

   // A capture on the accept edge takes priority over a simultaneous limpa.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         jogada_reg <= '0;
      end else if (captura) begin
         jogada_reg <= amostra_reg;
      end else if (limpa) begin
         jogada_reg <= '0;
      end
   end

   assign jogada          = jogada_reg;
   assign tem_jogada      = (estado_reg == ACEITA) &&  um_quente_reg;
   assign jogada_invalida = (estado_reg == ACEITA) && !um_quente_reg;
   assign ocupado         = (estado_reg != OCIOSO);
   assign db_estado       = estado_reg;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with the default debounce length of 4.
`timescale 1ns/1ps
module tb_detector_jogada;

   logic       clock;
   logic       reset;
   logic       limpa;
   logic [3:0] botoes;
   logic [3:0] jogada;
   logic       tem_jogada;
   logic       jogada_invalida;
   logic       ocupado;
   logic [2:0] db_estado;

   int checks;
   int erros;
   int ciclo;
   int cont_tem;
   int cont_inv;
   int ciclo_tem;
   int jogada_tem;
   int inicio;

   detector_jogada #(.DEBOUNCE_CICLOS(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .limpa          (limpa),
      .botoes         (botoes),
      .jogada         (jogada),
      .tem_jogada     (tem_jogada),
      .jogada_invalida(jogada_invalida),
      .ocupado        (ocupado),
      .db_estado      (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic verifica(input string tag, input int obs, input int esp);
      checks++;
      if (obs !== esp) begin
         erros++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // One clock edge; outputs are sampled 1 ns after it and pulses tallied.
   task automatic tick();
      @(posedge clock);
      #1;
      ciclo++;
      if (tem_jogada) begin
         cont_tem++;
         ciclo_tem  = ciclo;
         jogada_tem = int'(jogada);
      end
      if (jogada_invalida) cont_inv++;
   endtask

   task automatic aplica(input logic [3:0] valor, input int n);
      botoes = valor;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic zera_contagem();
      cont_tem  = 0;
      cont_inv  = 0;
      ciclo_tem = -1;
      inicio    = ciclo;
   endtask

   initial begin
      checks = 0; erros = 0; ciclo = 0;
      reset = 1'b1; limpa = 1'b0; botoes = 4'b0000;
      zera_contagem();
      repeat (2) @(posedge clock);
      #1;
      verifica("reset_jogada", int'(jogada), 0);
      verifica("reset_pulsos", int'({tem_jogada, jogada_invalida}), 0);
      verifica("reset_ocupado", int'(ocupado), 0);
      verifica("reset_estado", int'(db_estado), 0);
      reset = 1'b0;

      // Clean single press: pulse on the 4th sampled edge.
      zera_contagem();
      aplica(4'b0001, 10);
      verifica("t1_npulsos", cont_tem, 1);
      verifica("t1_ciclo", ciclo_tem - inicio, 4);
      verifica("t1_jogada_pulso", jogada_tem, 1);
      verifica("t1_invalida", cont_inv, 0);
      verifica("t1_ocupado_press", int'(ocupado), 1);
      verifica("t1_estado_press", int'(db_estado), 3);
      aplica(4'b0000, 6);
      verifica("t1_jogada_mantida", int'(jogada), 1);
      verifica("t1_ocioso", int'(db_estado), 0);

      // Bounce restarts the filter.
      zera_contagem();
      aplica(4'b0100, 2);
      aplica(4'b0000, 1);
      inicio = ciclo;
      aplica(4'b0100, 10);
      verifica("t2_npulsos", cont_tem, 1);
      verifica("t2_ciclo", ciclo_tem - inicio, 4);
      verifica("t2_jogada", int'(jogada), 4);
      aplica(4'b0000, 6);

      // Two buttons: invalid pulse only, jogada untouched.
      zera_contagem();
      aplica(4'b0011, 10);
      verifica("t3_ninvalida", cont_inv, 1);
      verifica("t3_ntem", cont_tem, 0);
      verifica("t3_jogada", int'(jogada), 4);
      aplica(4'b0000, 6);

      // Long hold with a short release glitch gives a single accept.
      zera_contagem();
      aplica(4'b1000, 50);
      aplica(4'b0000, 2);
      aplica(4'b1000, 10);
      verifica("t4_npulsos", cont_tem, 1);
      verifica("t4_jogada", int'(jogada), 8);
      aplica(4'b0000, 6);
      zera_contagem();
      aplica(4'b0010, 10);
      verifica("t4_nova_npulsos", cont_tem, 1);
      verifica("t4_nova_jogada", int'(jogada), 2);
      aplica(4'b0000, 6);

      // limpa while idle, then limpa on the accept edge.
      limpa = 1'b1;
      tick();
      limpa = 1'b0;
      verifica("t5_limpa_ocioso", int'(jogada), 0);
      aplica(4'b0001, 3);
      limpa = 1'b1;
      tick();
      limpa = 1'b0;
      verifica("t5_limpa_aceita_jogada", int'(jogada), 1);
      verifica("t5_limpa_aceita_pulso", int'(tem_jogada), 1);
      aplica(4'b0000, 6);

      // Asynchronous reset in the middle of the press filter.
      aplica(4'b0010, 2);
      verifica("t6_antes_estado", int'(db_estado), 1);
      reset = 1'b1;
      #1;
      verifica("t6_reset_jogada", int'(jogada), 0);
      verifica("t6_reset_ocupado", int'(ocupado), 0);
      verifica("t6_reset_estado", int'(db_estado), 0);
      verifica("t6_reset_pulsos", int'({tem_jogada, jogada_invalida}), 0);
      #2;
      reset = 1'b0;
      zera_contagem();
      aplica(4'b0010, 3);
      verifica("t6_sem_pulso_cedo", cont_tem, 0);
      aplica(4'b0010, 1);
      verifica("t6_pulso_completo", cont_tem, 1);
      verifica("t6_jogada", int'(jogada), 2);
      aplica(4'b0000, 6);

      $display("CHECKS %0d ERRORS %0d", checks, erros);
      $finish;
   end

endmodule
